rr_grant_indexer: RTL and testbench



---
 rtl/rr_grant_indexer.sv | 117 +++++++++++
 tb/tb_rr_grant_indexer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_indexer.sv
// Round-robin arbiter for eight requesters with a registered grant index and valid flag.
// Optional forced release after HOLD_MAX+1 cycles when RR_TIMEOUT_EN is defined.
module rr_grant_indexer #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e     state_q, state_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       busy_q, busy_d;
  logic [2:0] last_q, last_d;
  logic [2:0] pick;
  logic       hold_expired;
  logic       grant_exit;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_chk
    $error("HOLD_MAX must be within 1..255");
  end

  // Search starts one past the last owner; offset 8 wraps back onto last_q itself.
  always_comb begin
    logic       found;
    logic [2:0] cand;
    pick  = last_q;
    found = 1'b0;
    cand  = last_q;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (!found && req_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef RR_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;

  assign hold_expired = (hold_cnt_q == 8'(HOLD_MAX));
  assign hold_cnt_d   = (state_q == StGrant) ? hold_cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  assign grant_exit = done_i || !req_i[gnt_idx_q] || hold_expired;

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    last_d      = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          gnt_idx_d   = pick;
          gnt_valid_d = 1'b1;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (grant_exit) begin
          gnt_valid_d = 1'b0;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        // Dead cycle: requests ignored so two owners never see overlapping enables.
        last_d  = gnt_idx_q;
        state_d = StIdle;
      end
      default: begin
        gnt_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 3'd7;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
    end
  end

  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rr_grant_indexer.sv
// Directed bench for rr_grant_indexer; define RR_TIMEOUT_EN to exercise the forced release.
module tb_rr_grant_indexer;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;

  int unsigned passed;
  int unsigned total;
  int unsigned high_cnt;

`ifdef RR_TIMEOUT_EN
  localparam int unsigned HoldMax = 3;
`else
  localparam int unsigned HoldMax = 15;
`endif

  rr_grant_indexer #(
    .HOLD_MAX(HoldMax)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .done_i     (done),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] idx);
    chk({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    req    = 8'h00;
    done   = 1'b0;
    #1;
    chk("rst_idx", 32'(gnt_idx), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_noreq_valid", 32'(gnt_valid), 32'd0);

    // Single request after reset
    req = 8'h04;
    tick();
    chk_grant("single", 3'd2);
    chk("single_busy", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    chk("single_rel_valid", 32'(gnt_valid), 32'd0);
    chk("single_rel_busy", 32'(busy), 32'd1);
    chk("single_rel_idx", 32'(gnt_idx), 32'd2);
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);

    // last=2 so bit 4 wins over bit 2
    req = 8'h14;
    tick();
    chk_grant("last2", 3'd4);
    req = 8'h04;  // owner withdraws
    tick();
    chk("withdraw_valid", 32'(gnt_valid), 32'd0);
    tick();
    chk("turnaround_valid", 32'(gnt_valid), 32'd0);
    chk("turnaround_busy", 32'(busy), 32'd0);
    tick();
    chk_grant("after_withdraw", 3'd2);

    // done and withdrawal together, then done in IDLE
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("simul_valid", 32'(gnt_valid), 32'd0);
    chk("simul_busy", 32'(busy), 32'd1);
    tick();
    chk("simul_idle_busy", 32'(busy), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("idle_done_valid", 32'(gnt_valid), 32'd0);
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_idx", 32'(gnt_idx), 32'd2);

    // Fairness from a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      tick();
      chk_grant("fair", 3'(k));
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("fair_rel", 32'(gnt_valid), 32'd0);
      tick();
      chk("fair_idle", 32'(gnt_valid), 32'd0);
    end

    // Move last to 6, then wrap and skip
    req = 8'h40;
    tick();
    chk_grant("set6", 3'd6);
    req = 8'h03;
    tick();
    tick();
    tick();
    chk_grant("wrap0", 3'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    chk_grant("wrap1", 3'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h01;
    tick();

    // Hold behaviour with a persistent single requester
    tick();
    chk_grant("hold_start", 3'd0);
`ifdef RR_TIMEOUT_EN
    high_cnt = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (gnt_valid !== 1'b1) break;
      high_cnt++;
    end
    chk("timeout_high_cycles", high_cnt, 32'd4);
    tick();
    chk("timeout_low2", 32'(gnt_valid), 32'd0);
    tick();
    chk_grant("timeout_regrant", 3'd0);
`else
    high_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (gnt_valid === 1'b1) high_cnt++;
    end
    chk("held_100", high_cnt, 32'd100);
`endif
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    chk("hold_end_valid", 32'(gnt_valid), 32'd0);
    tick();

    // Asynchronous reset in the middle of a grant
    req = 8'h20;
    tick();
    chk_grant("pre_reset", 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(gnt_valid), 32'd0);
    chk("async_idx", 32'(gnt_idx), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_grant("post_reset", 3'd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
